sigmoid_lut_stage: RTL and testbench

Downstream consumer of sigmoid_addr_calc in the LSTM activation path. It accepts the 9-bit LUT address, the input sign bit and the out-of-range flag, and reads a synchronous sigmoid ROM. It then applies symmetry folding, sigmoid(-x) = 1 - sigmoid(x), and saturation, and emits a 12-bit unsigned Q1.11 activation value. It is a 2-stage valid/ready pipeline with a full-stall policy, feeding the gate multipliers.

---
 rtl/sigmoid_pkg.sv | 69 ++++++
 rtl/sigmoid_rom.sv | 35 +++
 rtl/sigmoid_lut_stage.sv | 86 ++++++++
 tb/tb_sigmoid_lut_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// ----------------------------------------------------------------------------
// sigmoid_pkg
// Shared constants and ROM-content function for the sigmoid activation path
// (sigmoid_addr_calc -> sigmoid_lut_stage).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sigmoid_pkg;

  // LUT address width; matches sigmoid_addr_calc.addr_out.
  localparam int ADDR_W       = 9;
  // Number of valid ROM entries: 0.0 to <6.0 in steps of 1/64.
  localparam int LUT_DEPTH    = 384;
  // Output width, unsigned Q1.11.
  localparam int OUT_W        = 12;
  // Q1.11 representation of 1.0, used for the symmetry fold.
  localparam int ONE          = 2048;
  // Value substituted for the ROM word when the input is out of range.
  localparam int SAT_VAL      = 2047;
  // Input activation format: 6 fractional bits, sign at bit 11.
  localparam int IN_FRAC_BITS = 6;
  localparam int ROM_SIZE     = 1 << ADDR_W;

  // Fixed-point precision used only while computing ROM contents.
  localparam int FX_FRAC      = 60;
  localparam int SQUARINGS    = 10;

  typedef logic [ADDR_W-1:0] lut_addr_t;
  typedef logic [OUT_W-1:0]  act_t;

  // ROM[a] = round(2048 / (1 + e^(-a/64))), clipped to SAT_VAL; 0 for unused
  // entries. Evaluated at elaboration only. e^(-x) is obtained as
  // (e^(-x/1024))^1024: a short Taylor series on the tiny argument, then ten
  // squarings, all in Q0.60 so the rounding is exact for every entry.
  function automatic act_t sigmoid_entry(input int unsigned a);
    logic [127:0] one_q;
    logic [127:0] t;
    logic [127:0] term;
    logic [127:0] y;
    logic [127:0] num;
    logic [127:0] den;
    logic [127:0] res;
    if (a >= LUT_DEPTH) begin
      return '0;
    end
    one_q = 128'd1 << FX_FRAC;
    t     = 128'(a) << (FX_FRAC - IN_FRAC_BITS - SQUARINGS);
    y     = one_q;
    term  = one_q;
    for (int n = 1; n <= 6; n++) begin
      term = ((term * t) >> FX_FRAC) / 128'(n);
      if (n % 2 == 1) y = y - term;
      else            y = y + term;
    end
    for (int k = 0; k < SQUARINGS; k++) begin
      y = (y * y) >> FX_FRAC;
    end
    // round(ONE * 1 / (1 + y)) = floor((2*ONE + (1 + y)) / (2 * (1 + y)))
    num = (128'(ONE) << (FX_FRAC + 1)) + one_q + y;
    den = (one_q + y) << 1;
    res = num / den;
    if (res > 128'(SAT_VAL)) res = 128'(SAT_VAL);
    return res[OUT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sigmoid_rom.sv
// ----------------------------------------------------------------------------
// sigmoid_rom
// Synchronous-read sigmoid ROM. Contents are computed at elaboration from the
// defining formula rather than loaded from an external hex image, so the
// table cannot drift from the fold/saturate arithmetic.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sigmoid_rom
  import sigmoid_pkg::*;
(
  input  logic              clk,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [OUT_W-1:0]  q_o
);

  logic [OUT_W-1:0] rom_tbl [ROM_SIZE];

  for (genvar a = 0; a < ROM_SIZE; a++) begin : g_rom
    localparam logic [OUT_W-1:0] ENTRY = sigmoid_entry(a);
    assign rom_tbl[a] = ENTRY;
  end

  // Registered read; holds its word while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (en_i) begin
      q_o <= rom_tbl[addr_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sigmoid_lut_stage.sv
// ----------------------------------------------------------------------------
// sigmoid_lut_stage
// Two-stage valid/ready pipeline: ROM read, then symmetry fold
// sigmoid(-x) = 1 - sigmoid(x) with out-of-range saturation. Full-stall
// policy: every stage advances together or not at all.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sigmoid_lut_stage
  import sigmoid_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_sign,
  input  logic              in_oor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  logic             en;
  logic [OUT_W-1:0] rom_q;
  logic             s1_valid_q;
  logic             s1_sign_q;
  logic             s1_oor_q;
  logic             s1_oor_d;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [OUT_W-1:0] out_data_d;
  logic [OUT_W-1:0] mag;

  // The whole pipe moves whenever the output register is empty or draining.
  assign en       = out_ready | ~out_valid_q;
  assign in_ready = en;

  // Addresses past the table are saturated even if upstream missed them.
  assign s1_oor_d = in_oor | (in_addr >= ADDR_W'(LUT_DEPTH));

  sigmoid_rom u_rom (
    .clk    (clk),
    .en_i   (en),
    .addr_i (in_addr),
    .q_o    (rom_q)
  );

  // Stage 1 control: sign, range flag and valid travel alongside the ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_oor_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= in_sign;
      s1_oor_q   <= s1_oor_d;
    end
  end

  // Saturate then fold. mag never exceeds 2047, so ONE - mag stays in
  // 1..2048 and fits OUT_W bits without wrapping.
  always_comb begin
    mag        = s1_oor_q ? OUT_W'(SAT_VAL) : rom_q;
    out_data_d = s1_sign_q ? (OUT_W'(ONE) - mag) : mag;
  end

  // Stage 2 output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_lut_stage.sv
// ----------------------------------------------------------------------------
// tb_sigmoid_lut_stage
// Self-checking bench for sigmoid_lut_stage against a real-arithmetic model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sigmoid_lut_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_addr;
  logic        in_sign;
  logic        in_oor;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sigmoid_lut_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_sign   (in_sign),
    .in_oor    (in_oor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Reference: sigmoid from the exponential, saturation, and 1 - s folding.
  function automatic logic [11:0] model(input int a, input bit s, input bit o);
    int  mag;
    real r;
    if (o || a >= 384) begin
      mag = 2047;
    end else begin
      r   = 2048.0 / (1.0 + $exp(-real'(a) / 64.0));
      mag = $rtoi(r + 0.5);
      if (mag > 2047) mag = 2047;
    end
    return s ? 12'(2048 - mag) : 12'(mag);
  endfunction

  // One cycle of stimulus; reports what happens at the coming rising edge.
  task automatic drive(input bit v, input int a, input bit s, input bit o, input bit r,
                       output bit ihs, output bit ohs, output logic [11:0] od,
                       output logic ov, output logic ir);
    @(negedge clk);
    in_valid  = v;
    in_addr   = 9'(a);
    in_sign   = s;
    in_oor    = o;
    out_ready = r;
    #1;
    ov  = out_valid;
    od  = out_data;
    ir  = in_ready;
    ihs = v && (ir === 1'b1);
    ohs = (ov === 1'b1) && r;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_addr = 9'd32; in_sign = 1'b0; in_oor = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", out_data); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    int          da   [9] = '{0, 32, 32, 192, 0, 0, 400, 383, 0};
    bit          ds   [9] = '{0, 1, 0, 0, 0, 1, 0, 0, 1};
    bit          dov  [9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [11:0] dexp [9] = '{12'h400, 12'h305, 12'h4FB, 12'h79F, 12'h7FF,
                              12'h001, 12'h7FF, 12'h7FB, 12'h400};
    bit ihs, ohs; logic [11:0] od; logic ov, ir;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, da[i], ds[i], dov[i], 1'b1, ihs, ohs, od, ov, ir);
      checks++;
      if (!ihs) begin errors++; $display("FAIL dir_accept[%0d]: got in_ready %b expected 1", i, ir); end
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1, ihs, ohs, od, ov, ir);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL dir_early[%0d]: got out_valid %b expected 0", i, ov); end
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1, ihs, ohs, od, ov, ir);
      checks++;
      if (ov !== 1'b1 || od !== dexp[i]) begin
        errors++;
        $display("FAIL dir_data[%0d] addr=%0d sign=%0b oor=%0b: got v=%b %h expected v=1 %h",
                 i, da[i], ds[i], dov[i], ov, od, dexp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          words [4] = '{0, 32, 64, 96};
    logic [11:0] got_q [$];
    logic [11:0] held;
    int sent = 0;
    bit ihs, ohs, r; logic [11:0] od; logic ov, ir;
    held = '0;
    for (int c = 0; c < 14; c++) begin
      r = !(c >= 3 && c <= 5);
      drive(sent < 4, (sent < 4) ? words[sent] : 0, 1'b0, 1'b0, r, ihs, ohs, od, ov, ir);
      if (ihs) sent++;
      if (ohs) got_q.push_back(od);
      if (c == 3) held = od;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (ir !== 1'b0 || ov !== 1'b1) begin
          errors++; $display("FAIL bp_stall_in_ready[c%0d]: got in_ready=%b out_valid=%b expected 0/1", c, ir, ov);
        end
        checks++;
        if (od !== held) begin errors++; $display("FAIL bp_stable[c%0d]: got %h expected %h", c, od, held); end
      end
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d expected 4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i] !== model(words[i], 1'b0, 1'b0)) begin
        errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_q[i], model(words[i], 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_stream();
    logic [11:0] exp_q [$];
    int sent = 0, got = 0, a;
    bit s, o, v, r, ihs, ohs; logic [11:0] od; logic ov, ir;
    a = $urandom_range(0, 511); s = 1'($urandom_range(0, 1)); o = ($urandom_range(0, 7) == 0);
    for (int c = 0; c < 3000 && got < 100; c++) begin
      v = (sent < 100) && ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 7);
      drive(v, a, s, o, r, ihs, ohs, od, ov, ir);
      if (ov === 1'b1 && !r) begin
        checks++;
        if (ir !== 1'b0) begin errors++; $display("FAIL stream_stall_ready[c%0d]: got %b expected 0", c, ir); end
      end
      if (ohs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got %h expected no word", od);
        end else begin
          if (od !== exp_q[0]) begin
            errors++; $display("FAIL stream_data[%0d]: got %h expected %h", got, od, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (ihs) begin
        exp_q.push_back(model(a, s, o));
        sent++;
        a = $urandom_range(0, 511); s = 1'($urandom_range(0, 1)); o = ($urandom_range(0, 7) == 0);
      end
    end
    checks++;
    if (got != 100) begin errors++; $display("FAIL stream_count: got %0d expected 100", got); end
  endtask

  task automatic test_back_to_back();
    int a [20];
    bit ihs, ohs; logic [11:0] od; logic ov, ir;
    for (int i = 0; i < 20; i++) a[i] = $urandom_range(0, 383);
    for (int c = 0; c < 22; c++) begin
      drive(c < 20, (c < 20) ? a[c] : 0, 1'b1, 1'b0, 1'b1, ihs, ohs, od, ov, ir);
      if (c < 20) begin
        checks++;
        if (!ihs) begin errors++; $display("FAIL b2b_accept[c%0d]: got in_ready %b expected 1", c, ir); end
      end
      if (c >= 2) begin
        checks++;
        if (!ohs || od !== model(a[c-2], 1'b1, 1'b0)) begin
          errors++; $display("FAIL b2b_out[c%0d]: got v=%b %h expected v=1 %h", c, ov, od, model(a[c-2], 1'b1, 1'b0));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ihs, ohs; logic [11:0] od; logic ov, ir;
    drive(1'b1, 10, 1'b0, 1'b0, 1'b0, ihs, ohs, od, ov, ir);
    drive(1'b1, 20, 1'b1, 1'b0, 1'b0, ihs, ohs, od, ov, ir);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, ihs, ohs, od, ov, ir);
    checks++;
    if (ov !== 1'b1 || od !== model(10, 1'b0, 1'b0)) begin
      errors++; $display("FAIL rstmid_pre: got v=%b %h expected v=1 %h", ov, od, model(10, 1'b0, 1'b0));
    end
    #2;
    rst = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 12'h000) begin errors++; $display("FAIL rstmid_data: got %h expected 000", out_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 64, 1'b1, 1'b0, 1'b1, ihs, ohs, od, ov, ir);
    checks++;
    if (!ihs || ov !== 1'b0) begin errors++; $display("FAIL rstmid_c0: got ready=%b valid=%b expected 1/0", ir, ov); end
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, ihs, ohs, od, ov, ir);
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got valid=%b %h expected 0", ov, od); end
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, ihs, ohs, od, ov, ir);
    checks++;
    if (ov !== 1'b1 || od !== model(64, 1'b1, 1'b0)) begin
      errors++; $display("FAIL rstmid_new: got v=%b %h expected v=1 %h", ov, od, model(64, 1'b1, 1'b0));
    end
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, ihs, ohs, od, ov, ir);
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL rstmid_after: got valid=%b expected 0", ov); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
